ace_snoop_responder: RTL and testbench

//  Master-side ACE snoop responder: accepts one snoop on the AC channel, looks up the local cache,

---
 rtl/ace_snoop_pkg.sv | 34 +++
 rtl/snoop_resp_decode.sv | 52 +++++
 rtl/ace_snoop_responder.sv | 125 ++++++++++++
 tb/tb_ace_snoop_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop responder: ACSNOOP opcodes, CRRESP bit
// positions, cache state-update codes and the responder FSM states.
package ace_snoop_pkg;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  localparam int unsigned CR_DT = 0;
  localparam int unsigned CR_ERR = 1;
  localparam int unsigned CR_PD = 2;
  localparam int unsigned CR_IS = 3;
  localparam int unsigned CR_WU = 4;

  localparam logic [1:0] UPD_NONE  = 2'b00;
  localparam logic [1:0] UPD_CLEAN = 2'b01;
  localparam logic [1:0] UPD_INVAL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_HOLD,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } snoop_state_t;

endpackage

// File: rtl/snoop_resp_decode.sv
// Combinational snoop response decode: opcode plus lookup result to CRRESP and
// the local cache state update to apply once the snoop completes.
module snoop_resp_decode
  import ace_snoop_pkg::*;
(
  input  logic [3:0] acsnoop,
  input  logic       hit,
  input  logic       dirty,
  input  logic       shared,
  output logic [4:0] crresp,
  output logic [1:0] state_upd
);

  always_comb begin
    crresp    = '0;
    state_upd = UPD_NONE;
    case (acsnoop)
      SNP_READ_ONCE, SNP_READ_CLEAN: if (hit) begin
        crresp[CR_DT] = 1'b1;
        crresp[CR_IS] = 1'b1;
        crresp[CR_WU] = !shared;
      end
      SNP_READ_SHARED, SNP_READ_NSD: if (hit) begin
        crresp[CR_DT] = 1'b1;
        crresp[CR_IS] = 1'b1;
        crresp[CR_PD] = dirty;
        crresp[CR_WU] = !shared;
        state_upd     = dirty ? UPD_CLEAN : UPD_NONE;
      end
      SNP_READ_UNIQUE: if (hit) begin
        crresp[CR_DT] = 1'b1;
        crresp[CR_PD] = dirty;
        crresp[CR_WU] = !shared;
        state_upd     = UPD_INVAL;
      end
      SNP_CLEAN_SHARED: if (hit) begin
        crresp[CR_DT] = dirty;
        crresp[CR_PD] = dirty;
        crresp[CR_IS] = 1'b1;
        state_upd     = dirty ? UPD_CLEAN : UPD_NONE;
      end
      SNP_CLEAN_INVALID: if (hit) begin
        crresp[CR_DT] = dirty;
        crresp[CR_PD] = dirty;
        state_upd     = UPD_INVAL;
      end
      SNP_MAKE_INVALID: if (hit) state_upd = UPD_INVAL;
      default: crresp[CR_ERR] = 1'b1;
    endcase
  end

endmodule

// File: rtl/ace_snoop_responder.sv
// Master-side ACE snoop responder: accepts a snoop, looks up the local cache,
// answers on CRRESP and streams the buffered line once the aggregator grants it.
module ace_snoop_responder
  import ace_snoop_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 128,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   acvalid,
  output logic                   acready,
  input  logic [ADDR_WIDTH-1:0]  acaddr,
  input  logic [3:0]             acsnoop,
  output logic                   tag_req,
  output logic [ADDR_WIDTH-1:0]  tag_addr,
  input  logic                   tag_hit,
  input  logic                   tag_dirty,
  input  logic                   tag_shared,
  input  logic [DATA_SIZE*4-1:0] line_data,
  output logic [1:0]             state_upd,
  output logic [4:0]             crresp,
  output logic                   crresp_vld,
  output logic                   done_data,
  input  logic                   start,
  input  logic                   stop,
  output logic [DATA_SIZE-1:0]   cache_line_out
);

  snoop_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [3:0]             snoop_q;
  logic [DATA_SIZE*4-1:0] line_q;
  logic [1:0]             beat_q;
  logic [1:0]             upd_q;
  logic [4:0]             crresp_q;
  logic [DATA_SIZE-1:0]   beat_out_q;
  logic [4:0]             dec_crresp;
  logic [1:0]             dec_upd;

  snoop_resp_decode u_decode (
    .acsnoop   (snoop_q),
    .hit       (tag_hit),
    .dirty     (tag_dirty),
    .shared    (tag_shared),
    .crresp    (dec_crresp),
    .state_upd (dec_upd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (acvalid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_RESP;
      ST_RESP:   state_d = dec_crresp[CR_DT] ? ST_HOLD : ST_DONE;
      ST_HOLD: begin
        if (start)     state_d = ST_WAIT;
        else if (stop) state_d = ST_DONE;
      end
      ST_WAIT:   state_d = ST_SEND;
      ST_SEND:   if (beat_q == 2'd3) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The line is shifted out LSB-first so the next beat is always the low slice.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      snoop_q    <= '0;
      line_q     <= '0;
      beat_q     <= '0;
      upd_q      <= UPD_NONE;
      crresp_q   <= '0;
      beat_out_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (acvalid) begin
          addr_q  <= acaddr;
          snoop_q <= acsnoop;
        end
        ST_RESP: begin
          crresp_q <= dec_crresp;
          upd_q    <= dec_upd;
          if (dec_crresp[CR_DT]) line_q <= line_data;
        end
        ST_HOLD: if (!start && stop) line_q <= '0;
        ST_WAIT: begin
          beat_out_q <= line_q[DATA_SIZE-1:0];
          line_q     <= {{DATA_SIZE{1'b0}}, line_q[DATA_SIZE*4-1:DATA_SIZE]};
          beat_q     <= '0;
        end
        ST_SEND: begin
          if (beat_q == 2'd3) begin
            beat_out_q <= '0;
          end else begin
            beat_out_q <= line_q[DATA_SIZE-1:0];
            line_q     <= {{DATA_SIZE{1'b0}}, line_q[DATA_SIZE*4-1:DATA_SIZE]};
            beat_q     <= beat_q + 2'd1;
          end
        end
        ST_DONE: begin
          crresp_q <= '0;
          upd_q    <= UPD_NONE;
          line_q   <= '0;
          beat_q   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign acready        = (state_q == ST_IDLE);
  assign tag_req        = (state_q == ST_LOOKUP);
  assign tag_addr       = addr_q;
  assign crresp         = crresp_q;
  assign crresp_vld     = state_q inside {ST_HOLD, ST_WAIT, ST_SEND, ST_DONE};
  assign done_data      = state_q inside {ST_HOLD, ST_WAIT, ST_SEND};
  assign state_upd      = (state_q == ST_DONE) ? upd_q : UPD_NONE;
  assign cache_line_out = beat_out_q;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed scenarios plus random
// snoops checked against an opcode-rule reference model.
module tb_ace_snoop_responder;

  localparam int unsigned DS = 128;
  localparam int unsigned AW = 32;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic            acvalid;
  logic            acready;
  logic [AW-1:0]   acaddr;
  logic [3:0]      acsnoop;
  logic            tag_req;
  logic [AW-1:0]   tag_addr;
  logic            tag_hit, tag_dirty, tag_shared;
  logic [DS*4-1:0] line_data;
  logic [1:0]      state_upd;
  logic [4:0]      crresp;
  logic            crresp_vld;
  logic            done_data;
  logic            start, stop;
  logic [DS-1:0]   cache_line_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit            pend_valid = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_op;

  always #5 ACLK = ~ACLK;

  ace_snoop_responder #(.DATA_SIZE(DS), .ADDR_WIDTH(AW)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET), .acvalid(acvalid), .acready(acready),
    .acaddr(acaddr), .acsnoop(acsnoop), .tag_req(tag_req), .tag_addr(tag_addr),
    .tag_hit(tag_hit), .tag_dirty(tag_dirty), .tag_shared(tag_shared),
    .line_data(line_data), .state_upd(state_upd), .crresp(crresp),
    .crresp_vld(crresp_vld), .done_data(done_data), .start(start), .stop(stop),
    .cache_line_out(cache_line_out)
  );

  // Reference: returns {state_upd, WasUnique, IsShared, PassDirty, Error, DataTransfer}
  function automatic logic [6:0] ref_resp(input logic [3:0] op, input logic hit,
                                          input logic dirty, input logic shared);
    logic dt, er, pd, sh, wu;
    logic [1:0] upd;
    dt = 0; er = 0; pd = 0; sh = 0; wu = 0; upd = 2'd0;
    if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13})) er = 1;
    else if (hit) begin
      if (op == 4'd0 || op == 4'd2) begin dt = 1; sh = 1; wu = !shared; end
      else if (op == 4'd1 || op == 4'd3) begin
        dt = 1; sh = 1; pd = dirty; wu = !shared; upd = dirty ? 2'd1 : 2'd0;
      end
      else if (op == 4'd7) begin dt = 1; pd = dirty; wu = !shared; upd = 2'd2; end
      else if (op == 4'd8) begin dt = dirty; pd = dirty; sh = 1; upd = dirty ? 2'd1 : 2'd0; end
      else if (op == 4'd9) begin dt = dirty; pd = dirty; upd = 2'd2; end
      else upd = 2'd2;
    end
    return {upd, wu, sh, pd, er, dt};
  endfunction

  function automatic logic [DS*4-1:0] rand_line();
    logic [DS*4-1:0] l;
    for (int w = 0; w < DS*4/32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  // mode: 0 start, 1 stop, 2 start+stop together. abort_beat >= 0 resets during that SEND beat.
  task automatic run_snoop(input logic [3:0] op, input logic hit, input logic dirty,
                           input logic shared, input logic [DS*4-1:0] line,
                           input logic [AW-1:0] addr, input int unsigned hold,
                           input int unsigned mode, input int abort_beat);
    logic [6:0]    exp;
    logic [DS-1:0] beat;
    exp = ref_resp(op, hit, dirty, shared);
    acvalid = 1'b1; acaddr = addr; acsnoop = op;
    n_cmp++; if (acready !== 1'b1) begin n_bad++; $display("FAIL acready_idle: got %b want 1", acready); end
    @(posedge ACLK); #1;
    if (pend_valid) begin acaddr = pend_addr; acsnoop = pend_op; end else acvalid = 1'b0;
    start = 1'($urandom); stop = 1'($urandom);
    n_cmp++; if ({tag_req, acready, crresp_vld} !== 3'b100) begin n_bad++;
      $display("FAIL lookup_ctl: got req/rdy/vld %b want 100", {tag_req, acready, crresp_vld}); end
    n_cmp++; if (tag_addr !== addr) begin n_bad++; $display("FAIL tag_addr: got %h want %h", tag_addr, addr); end
    @(posedge ACLK); #1;
    tag_hit = hit; tag_dirty = dirty; tag_shared = shared; line_data = line;
    start = 1'($urandom); stop = 1'($urandom);
    n_cmp++; if ({tag_req, acready, crresp_vld} !== 3'b000) begin n_bad++;
      $display("FAIL resp_ctl: got req/rdy/vld %b want 000", {tag_req, acready, crresp_vld}); end
    @(posedge ACLK); #1;
    tag_hit = 1'($urandom); tag_dirty = 1'($urandom); tag_shared = 1'($urandom); line_data = rand_line();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (crresp !== exp[4:0] || crresp_vld !== 1'b1) begin n_bad++;
      $display("FAIL crresp: got %b vld %b want %b vld 1", crresp, crresp_vld, exp[4:0]); end
    if (exp[0]) begin
      for (int i = 0; i < int'(hold); i++) begin
        n_cmp++; if ({done_data, acready, state_upd} !== 4'b1000 || cache_line_out !== '0) begin n_bad++;
          $display("FAIL hold: got dd/rdy/upd %b line %h want 1000 line 0", {done_data, acready, state_upd}, cache_line_out); end
        @(posedge ACLK); #1;
      end
      n_cmp++; if (done_data !== 1'b1) begin n_bad++; $display("FAIL done_data_T: got %b want 1", done_data); end
      start = (mode != 1); stop = (mode != 0);
      @(posedge ACLK); #1;
      start = 1'b0; stop = 1'b0;
      if (mode != 1) begin
        n_cmp++; if (done_data !== 1'b1 || cache_line_out !== '0) begin n_bad++;
          $display("FAIL wait: got dd %b line %h want dd 1 line 0", done_data, cache_line_out); end
        start = 1'($urandom); stop = 1'($urandom);
        @(posedge ACLK); #1;
        for (int k = 0; k < 4; k++) begin
          beat = line[k*DS +: DS];
          n_cmp++; if (cache_line_out !== beat) begin n_bad++;
            $display("FAIL beat%0d: got %h want %h", k, cache_line_out, beat); end
          n_cmp++; if ({done_data, crresp_vld, acready, state_upd} !== 5'b11000) begin n_bad++;
            $display("FAIL send_ctl%0d: got %b want 11000", k, {done_data, crresp_vld, acready, state_upd}); end
          if (k == abort_beat) begin
            ARESET = 1'b1;
            @(posedge ACLK); #1;
            ARESET = 1'b0; start = 1'b0; stop = 1'b0;
            n_cmp++; if ({acready, tag_req, crresp_vld, done_data, state_upd, crresp} !== 11'b10000000000
                         || cache_line_out !== '0 || tag_addr !== '0) begin n_bad++;
              $display("FAIL reset_mid: got rdy/req/vld/dd/upd/cr %b line %h addr %h want 10000000000 0 0",
                       {acready, tag_req, crresp_vld, done_data, state_upd, crresp}, cache_line_out, tag_addr); end
            @(posedge ACLK); #1;
            n_cmp++; if (state_upd !== 2'b00 || acready !== 1'b1) begin n_bad++;
              $display("FAIL reset_no_upd: got upd %b rdy %b want 00 1", state_upd, acready); end
            return;
          end
          start = 1'($urandom); stop = 1'($urandom);
          @(posedge ACLK); #1;
        end
        start = 1'b0; stop = 1'b0;
      end
    end
    n_cmp++; if (state_upd !== exp[6:5]) begin n_bad++; $display("FAIL state_upd: got %b want %b", state_upd, exp[6:5]); end
    n_cmp++; if ({crresp_vld, done_data, acready} !== 3'b100 || cache_line_out !== '0 || crresp !== exp[4:0]) begin n_bad++;
      $display("FAIL done: got vld/dd/rdy %b cr %b line %h want 100 cr %b line 0",
               {crresp_vld, done_data, acready}, crresp, cache_line_out, exp[4:0]); end
    start = 1'($urandom); stop = 1'($urandom);
    @(posedge ACLK); #1;
    start = 1'b0; stop = 1'b0;
    n_cmp++; if ({acready, crresp_vld, done_data, state_upd, crresp} !== 10'b1000000000) begin n_bad++;
      $display("FAIL back_idle: got rdy/vld/dd/upd/cr %b want 1000000000", {acready, crresp_vld, done_data, state_upd, crresp}); end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; acvalid = 1'b1; acaddr = $urandom; acsnoop = 4'd7;
    start = 1'b1; stop = 1'b0;
    tag_hit = 1'b1; tag_dirty = 1'b1; tag_shared = 1'b0; line_data = rand_line();
    repeat (3) @(posedge ACLK);
    #1;
    n_cmp++; if ({acready, tag_req, crresp_vld, done_data, state_upd, crresp} !== 11'b10000000000
                 || cache_line_out !== '0 || tag_addr !== '0) begin n_bad++;
      $display("FAIL reset: got rdy/req/vld/dd/upd/cr %b line %h addr %h want 10000000000 0 0",
               {acready, tag_req, crresp_vld, done_data, state_upd, crresp}, cache_line_out, tag_addr); end
    ARESET = 1'b0; acvalid = 1'b0; start = 1'b0;
    @(posedge ACLK); #1;
  endtask

  task automatic test_read_shared_dirty();
    run_snoop(4'b0001, 1'b1, 1'b1, 1'b1, {128'hD, 128'hC, 128'hB, 128'hA}, 32'h1000_0040, 1, 0, -1);
  endtask

  task automatic test_miss();
    run_snoop(4'b0111, 1'b0, 1'b1, 1'b0, rand_line(), 32'h2000_0080, 0, 0, -1);
  endtask

  task automatic test_stop();
    run_snoop(4'b0010, 1'b1, 1'b0, 1'b0, rand_line(), 32'h3000_00C0, 2, 1, -1);
  endtask

  task automatic test_start_stop();
    run_snoop(4'b0000, 1'b1, 1'b0, 1'b1, rand_line(), 32'h4000_0100, 0, 2, -1);
  endtask

  task automatic test_back_to_back();
    pend_valid = 1'b1; pend_addr = 32'h5555_0140; pend_op = 4'b0011;
    run_snoop(4'b0111, 1'b1, 1'b0, 1'b0, rand_line(), 32'h5000_0180, 1, 0, -1);
    pend_valid = 1'b0;
    run_snoop(pend_op, 1'b1, 1'b1, 1'b0, rand_line(), pend_addr, 0, 0, -1);
  endtask

  task automatic test_reset_mid();
    run_snoop(4'b0111, 1'b1, 1'b1, 1'b0, rand_line(), 32'h6000_01C0, 0, 0, 1);
  endtask

  task automatic test_illegal();
    run_snoop(4'b0100, 1'b1, 1'b1, 1'b0, rand_line(), 32'h7000_0200, 0, 0, -1);
    run_snoop(4'b1111, 1'b0, 1'b0, 1'b0, rand_line(), 32'h7000_0240, 0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_snoop(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rand_line(), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 2), -1);
  endtask

  initial begin
    test_reset();
    test_read_shared_dirty();
    test_miss();
    test_stop();
    test_start_stop();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
